// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU function codes, FSM states
// and the latency-counter sizing helper.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter must hold the largest (latency - 1) value; one spare bit keeps it safe.
    function automatic int unsigned cnt_width(input int unsigned base_lat, input int unsigned mul_lat);
        return $clog2((base_lat > mul_lat) ? base_lat : mul_lat) + 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant; ptr selects the winner only when both are valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one multicycle-processor ALU between two requesters with round-robin
// fairness, per-op settle latency and a single outstanding operation.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BASE_LAT = 1,
    parameter int unsigned MUL_LAT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    localparam int unsigned CW = cnt_width(BASE_LAT, MUL_LAT);

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_y;
    logic             res_zero;
    logic [1:0]       rsp_valid;
    logic [1:0]       grant;
    logic             accept;
    logic [2:0]       sel_f;
    logic [CW-1:0]    lat_load;
    logic             rsp_taken;

    rr_arb2 u_rr_arb2 (
        .valid ({req1_valid, req0_valid}),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Ready is only offered while idle and out of reset, so one op is ever in flight.
    assign accept     = (state == IDLE) && !reset;
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    assign sel_f     = grant[1] ? req1_f : req0_f;
    assign lat_load  = (sel_f == ALU_MUL) ? CW'(MUL_LAT - 1) : CW'(BASE_LAT - 1);
    assign rsp_taken = owner ? rsp1_ready : rsp0_ready;

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_y     = res_y;
    assign rsp1_y     = res_y;
    assign rsp0_zero  = res_zero;
    assign rsp1_zero  = res_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            res_y     <= '0;
            res_zero  <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_a  <= grant[1] ? req1_a : req0_a;
                        alu_b  <= grant[1] ? req1_b : req0_b;
                        alu_f  <= sel_f;
                        owner  <= grant[1];
                        rr_ptr <= ~grant[1];
                        cnt    <= lat_load;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs stay frozen here; sample its output once it has settled.
                    if (cnt == '0) begin
                        res_y     <= alu_y;
                        res_zero  <= alu_zero;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and soak bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_y, rsp1_y;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .BASE_LAT(1), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero)
    );

    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [31:0] y;
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (f)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_MUL:  y = p[31:0];
            ALU_ANDN: y = a & ~b;
            ALU_ORN:  y = a | ~b;
            ALU_SUB:  y = a - b;
            default:  y = {31'd0, $signed(a) < $signed(b)};
        endcase
        return {(y == 32'd0), y};
    endfunction

    assign {alu_zero, alu_y} = alu_model(alu_a, alu_b, alu_f);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction
    function automatic logic rspv(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [32:0] rspzy(input int p);
        return (p == 1) ? {rsp1_zero, rsp1_y} : {rsp0_zero, rsp0_y};
    endfunction

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        if (p == 1) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_f = f;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_f = f;
        end
    endtask

    // Called one negedge after the accepting edge; returns when rsp is seen.
    task automatic wait_rsp(input int p, input logic [31:0] a, input logic [2:0] f,
                            input logic [31:0] ey, input logic ez, input int elat);
        int n = 1;
        while (!rspv(p) && n <= 20) begin
            check("exec_alu_f", 64'(alu_f), 64'(f));
            check("exec_alu_a", 64'(alu_a), 64'(a));
            @(negedge clk);
            n++;
        end
        check("rsp_valid", 64'(rspv(p)), 64'(1));
        check("latency", 64'(n), 64'(elat + 1));
        check("rsp_y_zero", 64'(rspzy(p)), 64'({ez, ey}));
        check("other_rsp_idle", 64'(rspv(1 - p)), 64'(0));
    endtask

    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                          input logic [31:0] ey, input logic ez, input int elat);
        set_req(p, 1'b1, a, b, f);
        #1;
        check("grant", 64'(rdy(p)), 64'(1));
        @(negedge clk);
        set_req(p, 1'b0, a, b, f);
        wait_rsp(p, a, f, ey, ez, elat);
        @(negedge clk);
        #1;
        check("rsp_cleared", 64'(rspv(p)), 64'(0));
    endtask

    // Requester discipline: once valid is raised it must hold until accepted.
    logic [67:0] hold0_q, hold1_q;
    logic        pend0_q = 1'b0, pend1_q = 1'b0;
    always @(posedge clk) begin
        if (!reset) begin
            if (pend0_q) assert ({req0_valid, req0_a, req0_b, req0_f} == hold0_q) else $error("req0 dropped before ready");
            if (pend1_q) assert ({req1_valid, req1_a, req1_b, req1_f} == hold1_q) else $error("req1 dropped before ready");
        end
        pend0_q <= req0_valid && !req0_ready && !reset;
        pend1_q <= req1_valid && !req1_ready && !reset;
        hold0_q <= {req0_valid, req0_a, req0_b, req0_f};
        hold1_q <= {req1_valid, req1_a, req1_b, req1_f};
    end

    // Soak state
    logic        sv[2], hs[2], rhs[2], rr[2];
    logic [31:0] sa[2], sb[2];
    logic [2:0]  sf[2];
    int          waits[2];
    logic [32:0] q0[$], q1[$];
    int          raised, issued;

    initial begin
        reset = 1'b1;
        set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 1'b0, 32'd0, 32'd0, ALU_AND);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
        check("rst_alu", 64'({alu_a, alu_f}), 64'(0));
        check("rst_rsp", 64'({rsp1_valid, rsp0_valid, rsp0_y}), 64'(0));
        set_req(0, 1'b0, 32'd0, 32'd0, ALU_AND);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single ADD, then a slow MUL on port 1
        run_op(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1);
        run_op(1, 32'd6, 32'd7, ALU_MUL, 32'd42, 1'b0, 3);

        // Contention straight out of reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 32'd9, 32'd9, ALU_SUB);
        set_req(1, 1'b1, 32'd3, 32'd4, ALU_SLT);
        #1;
        check("cont_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(negedge clk);
        set_req(0, 1'b0, 32'd9, 32'd9, ALU_SUB);
        #1;
        check("busy_ready", 64'({req1_ready, req0_ready}), 64'(0));
        wait_rsp(0, 32'd9, ALU_SUB, 32'd0, 1'b1, 1);
        @(negedge clk);
        set_req(0, 1'b1, 32'd9, 32'd9, ALU_SUB);
        #1;
        check("rr_grant", 64'({req1_ready, req0_ready}), 64'(2'b10));
        @(negedge clk);
        set_req(1, 1'b0, 32'd3, 32'd4, ALU_SLT);
        wait_rsp(1, 32'd3, ALU_SLT, 32'd1, 1'b0, 1);
        @(negedge clk);
        #1;
        check("rr_back", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(negedge clk);
        set_req(0, 1'b0, 32'd9, 32'd9, ALU_SUB);
        wait_rsp(0, 32'd9, ALU_SUB, 32'd0, 1'b1, 1);
        @(negedge clk);

        // Backpressure on port 0 with port 1 waiting
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 32'h0F, 32'hF0, ALU_OR);
        #1;
        check("bp_grant", 64'(req0_ready), 64'(1));
        @(negedge clk);
        set_req(0, 1'b0, 32'h0F, 32'hF0, ALU_OR);
        set_req(1, 1'b1, 32'hFF, 32'h0F, ALU_ANDN);
        wait_rsp(0, 32'h0F, ALU_OR, 32'hFF, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp0_valid, rsp0_y}), 64'({1'b1, 32'hFF}));
            check("bp_ready", 64'({req1_ready, req0_ready}), 64'(0));
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release", 64'({rsp0_valid, req1_ready}), 64'(2'b01));
        @(negedge clk);
        set_req(1, 1'b0, 32'hFF, 32'h0F, ALU_ANDN);
        wait_rsp(1, 32'hFF, ALU_ANDN, 32'hF0, 1'b0, 1);
        @(negedge clk);

        // Reset in the middle of a MUL
        set_req(0, 1'b1, 32'd5, 32'd5, ALU_MUL);
        #1;
        check("mr_grant", 64'(req0_ready), 64'(1));
        @(negedge clk);
        set_req(0, 1'b0, 32'd5, 32'd5, ALU_MUL);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_alu", 64'({alu_a, alu_b[2:0], alu_f}), 64'(0));
        check("mr_out", 64'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mr_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'(0));
        end
        run_op(0, 32'hF0, 32'h3C, ALU_AND, 32'h30, 1'b0, 1);

        // Random soak with a scoreboard
        raised = 0;
        issued = 0;
        for (int p = 0; p < 2; p++) begin
            sv[p] = 1'b0; hs[p] = 1'b0; rhs[p] = 1'b0; rr[p] = 1'b1; waits[p] = 0;
            sa[p] = 32'd0; sb[p] = 32'd0; sf[p] = 3'd0;
        end
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (rhs[p]) begin
                    if (p == 1) void'(q1.pop_front()); else void'(q0.pop_front());
                    rhs[p] = 1'b0;
                end
                if (hs[p]) begin
                    if (p == 1) q1.push_back(alu_model(sa[p], sb[p], sf[p]));
                    else        q0.push_back(alu_model(sa[p], sb[p], sf[p]));
                    issued++;
                    waits[p] = 0;
                    if (sv[1 - p]) waits[1 - p]++;
                    check("starvation", 64'(waits[1 - p] <= 1), 64'(1));
                    sv[p] = 1'b0;
                    hs[p] = 1'b0;
                end
                if (!sv[p] && raised < 2000 && $urandom_range(0, 2) != 0) begin
                    sv[p] = 1'b1;
                    sa[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    sb[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    sf[p] = 3'($urandom_range(0, 7));
                    raised++;
                end
                rr[p] = ($urandom_range(0, 3) != 0);
                set_req(p, sv[p], sa[p], sb[p], sf[p]);
            end
            rsp0_ready = rr[0];
            rsp1_ready = rr[1];
            #1;
            for (int p = 0; p < 2; p++) begin
                hs[p] = sv[p] && rdy(p);
                if (rspv(p) && rr[p]) begin
                    if (p == 1) begin
                        check("soak_q1_nonempty", 64'(q1.size() > 0), 64'(1));
                        if (q1.size() > 0) check("soak_rsp1", 64'(rspzy(1)), 64'(q1[0]));
                    end else begin
                        check("soak_q0_nonempty", 64'(q0.size() > 0), 64'(1));
                        if (q0.size() > 0) check("soak_rsp0", 64'(rspzy(0)), 64'(q0[0]));
                    end
                    rhs[p] = 1'b1;
                end
            end
            if (raised == 2000 && issued == 2000 && !sv[0] && !sv[1] && !rhs[0] && !rhs[1]
                && q0.size() == 0 && q1.size() == 0) break;
        end
        check("soak_issued", 64'(issued), 64'(2000));
        check("soak_drained", 64'(q0.size() + q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
